cla_pipe_addsub: RTL and testbench



---
 rtl/cla_pipe_addsub.sv | 213 +++++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
// Three-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking on both sides.
//
//   S1: register P = a ^ b_eff, G = a & b_eff and carry-in c0. In subtract
//       mode b_eff = ~b and c0 = ~cin.
//   S2: per-group generate/propagate (GG/GP), then a second-level lookahead
//       over the groups gives every group carry-in and the final carry out.
//   S3: per-bit carries by lookahead from the group carry-in; register
//       sum, cout, ovf and zero.
//
// One global advance enable moves the whole pipeline, bubbles included:
//   en = ~out_valid | out_ready, and in_ready = en.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   operand beat present
//   in_ready  out  block can accept a beat this cycle
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in (add) / borrow-in (sub)
//   sub       in   0 = add, 1 = subtract
//   out_valid out  result beat present
//   out_ready in   consumer takes the result this cycle
//   sum       out  WIDTH-bit result (modulo 2^WIDTH)
//   cout      out  carry out of MSB (sub: 1 = no borrow)
//   ovf       out  two's-complement overflow
//   zero      out  sum == 0
// -----------------------------------------------------------------------------
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    // Carry into position n of a lookahead block: every term is an
    // independent AND of one generate with the propagates above it, so no
    // carry ripples from one position to the next.
    function automatic logic lookahead(input logic [WIDTH-1:0] g,
                                       input logic [WIDTH-1:0] p,
                                       input logic             c_in,
                                       input int               n);
        logic term;
        logic res;
        res = 1'b0;
        for (int i = 0; i < n; i++) begin
            term = g[i];
            for (int j = i + 1; j < n; j++) begin
                term = term & p[j];
            end
            res = res | term;
        end
        term = c_in;
        for (int j = 0; j < n; j++) begin
            term = term & p[j];
        end
        res = res | term;
        return res;
    endfunction

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_p_r;
    logic [WIDTH-1:0] s1_g_r;
    logic             s1_c0_r;

    logic [NG-1:0]    gg_s;
    logic [NG-1:0]    gp_s;
    logic [NG:0]      gc_s;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_p_r;
    logic [WIDTH-1:0] s2_g_r;
    logic [NG:0]      s2_gc_r;

    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;

    assign en_s     = ~out_valid | out_ready;
    assign in_ready = en_s;

    // Operand conditioning for subtract: a - b - cin = a + ~b + ~cin.
    always_comb begin
        b_eff_s = {WIDTH{1'b0}};
        c0_s    = 1'b0;
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = ~cin;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end

    // Stage 1 registers: per-bit propagate/generate and carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_p_r     <= {WIDTH{1'b0}};
            s1_g_r     <= {WIDTH{1'b0}};
            s1_c0_r    <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            s1_p_r     <= a ^ b_eff_s;
            s1_g_r     <= a & b_eff_s;
            s1_c0_r    <= c0_s;
        end
    end

    // Group generate/propagate and second-level lookahead for group carry-ins.
    always_comb begin
        logic [WIDTH-1:0] gw;
        logic [WIDTH-1:0] pw;
        logic [WIDTH-1:0] ggw;
        logic [WIDTH-1:0] gpw;
        gw   = {WIDTH{1'b0}};
        pw   = {WIDTH{1'b0}};
        ggw  = {WIDTH{1'b0}};
        gpw  = {WIDTH{1'b0}};
        gg_s = {NG{1'b0}};
        gp_s = {NG{1'b0}};
        gc_s = {(NG + 1){1'b0}};
        for (int k = 0; k < NG; k++) begin
            gw            = {WIDTH{1'b0}};
            gw[GROUP-1:0] = s1_g_r[k*GROUP +: GROUP];
            pw            = {WIDTH{1'b0}};
            pw[GROUP-1:0] = s1_p_r[k*GROUP +: GROUP];
            // Group generate is the carry out of the group with carry-in 0.
            gg_s[k]       = lookahead(gw, pw, 1'b0, GROUP);
            gp_s[k]       = &s1_p_r[k*GROUP +: GROUP];
        end
        ggw[NG-1:0] = gg_s;
        gpw[NG-1:0] = gp_s;
        for (int k = 0; k <= NG; k++) begin
            gc_s[k] = lookahead(ggw, gpw, s1_c0_r, k);
        end
    end

    // Stage 2 registers: group carry-ins (plus final carry) and P/G.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_p_r     <= {WIDTH{1'b0}};
            s2_g_r     <= {WIDTH{1'b0}};
            s2_gc_r    <= {(NG + 1){1'b0}};
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_p_r     <= s1_p_r;
            s2_g_r     <= s1_g_r;
            s2_gc_r    <= gc_s;
        end
    end

    // Per-bit carries inside each group from its carry-in, then sum/flags.
    always_comb begin
        logic [WIDTH-1:0] gw;
        logic [WIDTH-1:0] pw;
        gw      = {WIDTH{1'b0}};
        pw      = {WIDTH{1'b0}};
        carry_s = {WIDTH{1'b0}};
        for (int k = 0; k < NG; k++) begin
            gw            = {WIDTH{1'b0}};
            gw[GROUP-1:0] = s2_g_r[k*GROUP +: GROUP];
            pw            = {WIDTH{1'b0}};
            pw[GROUP-1:0] = s2_p_r[k*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                carry_s[k*GROUP + i] = lookahead(gw, pw, s2_gc_r[k], i);
            end
        end
        sum_s = s2_p_r ^ carry_s;
        // Operand MSBs agree exactly when P[MSB] = 0; G[MSB] is then a[MSB].
        ovf_s = ~s2_p_r[WIDTH-1] & (sum_s[WIDTH-1] ^ s2_g_r[WIDTH-1]);
    end

    // Stage 3 registers drive the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en_s) begin
            out_valid <= s2_valid_r;
            sum       <= sum_s;
            cout      <= s2_gc_r[NG];
            ovf       <= ovf_s;
            zero      <= ~|sum_s;
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_addsub
// Self-checking bench for cla_pipe_addsub (WIDTH=16, GROUP=4). A scoreboard
// queue holds results computed with plain integer arithmetic; every retired
// output beat is compared against the head of the queue.
// -----------------------------------------------------------------------------
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_lat;

    typedef struct {
        logic [18:0] res;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference result packed as {cout, ovf, zero, sum}.
    function automatic logic [18:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic s);
        longint ux, uy, c, r, sx, sy, t;
        logic   co, ov;
        logic [15:0] res;
        ux = x;
        uy = y;
        c  = ci;
        sx = $signed(x);
        sy = $signed(y);
        if (!s) begin
            r  = ux + uy + c;
            co = (r >= 65536);
            t  = sx + sy + c;
        end else begin
            r  = ux - uy - c;
            co = (r >= 0);
            t  = sx - sy - c;
        end
        res = r[15:0];
        ov  = (t > 32767) || (t < -32768);
        return {co, ov, (res == 16'h0000), res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
    endtask

    task automatic set_rand(input logic v);
        set_in(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One clock cycle: sample handshakes mid-cycle, then advance past the edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {13'd0, cout, ovf, zero, sum}, {13'd0, e.res});
                if (chk_lat) check("latency", 32'(cyc - e.acc), 32'd3);
            end
        end else if (out_valid && !out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_held", 32'(out_valid), 32'd0);
            end else begin
                check("held_result", {13'd0, cout, ovf, zero, sum}, {13'd0, exp_q[0].res});
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
        end
        if (in_valid && in_ready) begin
            e.res = ref_model(a, b, cin, sub);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed corner cases, one isolated beat each, latency checked.
        set_in(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b0); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();
        set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1); step(); set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); repeat (4) step();

        // Streaming: 8 back-to-back beats, each must emerge exactly 3 cycles later.
        for (int i = 0; i < 8; i++) begin
            set_rand(1'b1);
            step();
        end
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) step();

        // Backpressure: fill, stall 5 cycles, release and drain.
        chk_lat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_rand(1'b1);
            out_ready = !(i >= 4 && i < 9);
            step();
        end
        out_ready = 1'b1;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) step();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            set_rand(1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (6) step();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-flight: two beats in, first one at the output, then reset.
        chk_lat = 1'b1;
        set_in(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0); step();
        set_in(1'b1, 16'h4321, 16'h0101, 1'b1, 1'b0); step();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);       step();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(sum),       32'd0);
        check("mid_rst_cout",      32'(cout),      32'd0);
        check("mid_rst_ovf",       32'(ovf),       32'd0);
        check("mid_rst_zero",      32'(zero),      32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) step();

        // A fresh beat after reset still works.
        set_in(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); step();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (5) step();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
